// File: rtl/read_tick_scheduler.sv
// Start/stop/single-step read-strobe generator: one-cycle TICK every DIV_ACTIVE+1 clocks, divisor
// reloaded through a valid/ready port at period boundaries. Optional square output: READ_CLK_SQUARE_OUT_EN.
module read_tick_scheduler #(
  parameter int COUNTER_WIDTH = 10,
  parameter int DEFAULT_DIV   = 1023
) (
  input  logic                     IN_50Mhz,
  input  logic                     RESET,
  input  logic                     START,
  input  logic                     STOP,
  input  logic                     STEP,
  input  logic                     CFG_VALID,
  input  logic [COUNTER_WIDTH-1:0] CFG_DIV,
  output logic                     CFG_READY,
  output logic                     TICK,
  output logic                     RUNNING,
  output logic [7:0]               TICK_COUNT
`ifdef READ_CLK_SQUARE_OUT_EN
  ,
  output logic                     OUT
`endif
);

  // Config handshake: CFG_DIV is captured on any edge where CFG_VALID && CFG_READY; CFG_READY stays
  // low until the captured divisor has been applied (next wrap, or next edge while idle).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } state_e;

  localparam logic [COUNTER_WIDTH-1:0] DEF_DIV = COUNTER_WIDTH'(DEFAULT_DIV);

  state_e                   state_q, state_d;
  logic [COUNTER_WIDTH-1:0] counter_q, counter_d;
  logic [COUNTER_WIDTH-1:0] div_active_q, div_active_d;
  logic [COUNTER_WIDTH-1:0] div_pending_q, div_pending_d;
  logic                     cfg_ready_q, cfg_ready_d;
  logic                     tick_q, tick_d;
  logic [7:0]               tick_count_q, tick_count_d;
  logic                     out_q, out_d;

  always_comb begin
    state_d       = state_q;
    counter_d     = counter_q;
    div_active_d  = div_active_q;
    div_pending_d = div_pending_q;
    cfg_ready_d   = cfg_ready_q;
    tick_d        = 1'b0;
    tick_count_d  = tick_count_q;

    case (state_q)
      S_IDLE: begin
        counter_d = '0;
        if (!STOP) begin
          if (START)     state_d = S_RUN;
          else if (STEP) state_d = S_STEP;
        end
      end
      S_RUN, S_STEP: begin
        if (STOP) begin
          state_d   = S_IDLE;
          counter_d = '0;
        end else if (counter_q < div_active_q) begin
          counter_d = counter_q + COUNTER_WIDTH'(1);
        end else begin
          counter_d = '0;
          tick_d    = 1'b1;
          if (state_q == S_STEP) state_d = S_IDLE;
        end
      end
      default: begin
        state_d   = S_IDLE;
        counter_d = '0;
      end
    endcase

    // A pending divisor only lands on a period boundary, so no period is ever cut or stretched.
    if (!cfg_ready_q && (tick_d || state_q == S_IDLE)) begin
      div_active_d = div_pending_q;
      cfg_ready_d  = 1'b1;
    end else if (CFG_VALID && cfg_ready_q) begin
      div_pending_d = CFG_DIV;
      cfg_ready_d   = 1'b0;
    end

    if (tick_d) tick_count_d = tick_count_q + 8'd1;
    out_d = out_q ^ tick_d;
  end

  always_ff @(posedge IN_50Mhz) begin
    if (RESET) begin
      state_q       <= S_IDLE;
      counter_q     <= '0;
      div_active_q  <= DEF_DIV;
      div_pending_q <= '0;
      cfg_ready_q   <= 1'b1;
      tick_q        <= 1'b0;
      tick_count_q  <= 8'd0;
    end else begin
      state_q       <= state_d;
      counter_q     <= counter_d;
      div_active_q  <= div_active_d;
      div_pending_q <= div_pending_d;
      cfg_ready_q   <= cfg_ready_d;
      tick_q        <= tick_d;
      tick_count_q  <= tick_count_d;
    end
  end

`ifdef READ_CLK_SQUARE_OUT_EN
  always_ff @(posedge IN_50Mhz) begin
    if (RESET) out_q <= 1'b0;
    else       out_q <= out_d;
  end
  assign OUT = out_q;
`else
  assign out_q = 1'b0;
`endif

  assign CFG_READY  = cfg_ready_q;
  assign TICK       = tick_q;
  assign RUNNING    = (state_q != S_IDLE);
  assign TICK_COUNT = tick_count_q;

endmodule

// File: tb/tb_read_tick_scheduler.sv
// Bench for read_tick_scheduler: fixed vector table, directed multi-cycle sequences and a random
// run, all checked every cycle against a period-level reference model.
module tb_read_tick_scheduler;

  localparam int CW = 10;
  localparam int DEF_DIV = 1023;

  logic          IN_50Mhz = 1'b0;
  logic          RESET = 1'b0, START = 1'b0, STOP = 1'b0, STEP = 1'b0, CFG_VALID = 1'b0;
  logic [CW-1:0] CFG_DIV = '0;
  logic          CFG_READY, TICK, RUNNING;
  logic [7:0]    TICK_COUNT;
`ifdef READ_CLK_SQUARE_OUT_EN
  logic          OUT;
`endif

  read_tick_scheduler #(.COUNTER_WIDTH(CW), .DEFAULT_DIV(DEF_DIV)) dut (
    .IN_50Mhz(IN_50Mhz), .RESET(RESET), .START(START), .STOP(STOP), .STEP(STEP),
    .CFG_VALID(CFG_VALID), .CFG_DIV(CFG_DIV), .CFG_READY(CFG_READY), .TICK(TICK),
    .RUNNING(RUNNING), .TICK_COUNT(TICK_COUNT)
`ifdef READ_CLK_SQUARE_OUT_EN
    , .OUT(OUT)
`endif
  );

  // clock / watchdog
  always #10 IN_50Mhz = ~IN_50Mhz;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tick_times[$];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  // reference model: mode 0 idle, 1 run, 2 step; period = div+1 cycles counted by elapsed
  int          m_mode = 0;
  int          m_elapsed = 0;
  int          m_div = DEF_DIV;
  logic [CW-1:0] exp_q[$];
  int          m_count = 0;
  bit          m_tick = 0;
  bit          m_out = 0;

  task automatic model_step();
    bit had_pend;
    bit hs;
    if (RESET) begin
      m_mode = 0; m_elapsed = 0; m_div = DEF_DIV; exp_q.delete();
      m_count = 0; m_tick = 0; m_out = 0;
    end else begin
      had_pend = (exp_q.size() != 0);
      hs = CFG_VALID && !had_pend;
      m_tick = 0;
      if (m_mode == 0) begin
        if (had_pend) m_div = int'(exp_q.pop_front());
        m_elapsed = 0;
        if (!STOP) begin
          if (START)     m_mode = 1;
          else if (STEP) m_mode = 2;
        end
      end else if (STOP) begin
        m_mode = 0;
        m_elapsed = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == m_div + 1) begin
          m_tick = 1;
          m_elapsed = 0;
          if (had_pend) m_div = int'(exp_q.pop_front());
          if (m_mode == 2) m_mode = 0;
        end
      end
      if (hs) exp_q.push_back(CFG_DIV);
      if (m_tick) begin
        m_count = (m_count + 1) % 256;
        m_out = ~m_out;
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // one clock: model advances on the edge, outputs compared 1 ns later
  task automatic step_clk();
    @(posedge IN_50Mhz);
    model_step();
    cyc++;
    #1;
    check("tick", int'(TICK), int'(m_tick));
    check("running", int'(RUNNING), int'(m_mode != 0));
    check("cfg_ready", int'(CFG_READY), int'(exp_q.size() == 0));
    check("tick_count", int'(TICK_COUNT), m_count);
`ifdef READ_CLK_SQUARE_OUT_EN
    check("out", int'(OUT), int'(m_out));
`endif
    if (TICK) tick_times.push_back(cyc);
  endtask

  // driver tasks
  task automatic clear_inputs();
    START = 0; STOP = 0; STEP = 0; CFG_VALID = 0; CFG_DIV = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RESET = 1;
    step_clk();
    step_clk();
    RESET = 0;
  endtask

  task automatic cfg_div(input int v);
    CFG_VALID = 1; CFG_DIV = CW'(v);
    step_clk();
    CFG_VALID = 0;
    step_clk();
  endtask

  task automatic pulse_start();
    START = 1;
    step_clk();
    START = 0;
  endtask

  typedef struct {
    bit            start, stop, step, valid;
    logic [CW-1:0] div;
    bit            e_tick, e_run, e_ready;
  } vec_t;

  vec_t vecs[16];
  int   s;
  int   ones;

  initial begin
    vecs[0]  = '{0, 0, 0, 1, 10'd3, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 10'd0, 0, 0, 1};
    vecs[2]  = '{0, 0, 1, 0, 10'd0, 0, 1, 1};
    vecs[3]  = '{0, 0, 0, 0, 10'd0, 0, 1, 1};
    vecs[4]  = '{0, 0, 0, 0, 10'd0, 0, 1, 1};
    vecs[5]  = '{0, 0, 0, 0, 10'd0, 0, 1, 1};
    vecs[6]  = '{0, 0, 0, 0, 10'd0, 1, 0, 1};
    vecs[7]  = '{0, 0, 0, 0, 10'd0, 0, 0, 1};
    vecs[8]  = '{1, 1, 0, 0, 10'd0, 0, 0, 1};
    vecs[9]  = '{1, 0, 1, 0, 10'd0, 0, 1, 1};
    vecs[10] = '{0, 0, 1, 0, 10'd0, 0, 1, 1};
    vecs[11] = '{0, 0, 0, 0, 10'd0, 0, 1, 1};
    vecs[12] = '{0, 0, 0, 0, 10'd0, 0, 1, 1};
    vecs[13] = '{0, 0, 0, 0, 10'd0, 1, 1, 1};
    vecs[14] = '{0, 0, 0, 0, 10'd0, 0, 1, 1};
    vecs[15] = '{0, 1, 0, 0, 10'd0, 0, 0, 1};

    // reset state
    do_reset();
    check("reset_tick", int'(TICK), 0);
    check("reset_running", int'(RUNNING), 0);
    check("reset_ready", int'(CFG_READY), 1);
    check("reset_count", int'(TICK_COUNT), 0);

    // default divisor: ticks 1024 and 2048 cycles after the START edge
    pulse_start();
    s = cyc;
    tick_times.delete();
    for (int i = 0; i < 2048; i++) step_clk();
    check("t1_ticks", tick_times.size(), 2);
    if (tick_times.size() >= 2) begin
      check("t1_first", tick_times[0] - s, 1024);
      check("t1_second", tick_times[1] - s, 2048);
    end
    check("t1_count", int'(TICK_COUNT), 2);

    // vector table: config in idle, single step, START/STOP priority, START over STEP
    do_reset();
    for (int i = 0; i < 16; i++) begin
      START = vecs[i].start; STOP = vecs[i].stop; STEP = vecs[i].step;
      CFG_VALID = vecs[i].valid; CFG_DIV = vecs[i].div;
      step_clk();
      check($sformatf("vec%0d_tick", i), int'(TICK), int'(vecs[i].e_tick));
      check($sformatf("vec%0d_running", i), int'(RUNNING), int'(vecs[i].e_run));
      check($sformatf("vec%0d_ready", i), int'(CFG_READY), int'(vecs[i].e_ready));
    end
    clear_inputs();

    // divisor change mid-period, second offer held off until applied
    do_reset();
    cfg_div(3);
    pulse_start();
    s = cyc;
    tick_times.delete();
    CFG_VALID = 1; CFG_DIV = 10'd7;
    step_clk();
    check("t3_ready_after_offer", int'(CFG_READY), 0);
    CFG_DIV = 10'd5;
    step_clk();
    check("t3_second_offer_blocked", int'(CFG_READY), 0);
    CFG_VALID = 0;
    for (int i = 0; i < 18; i++) step_clk();
    check("t3_ticks", tick_times.size(), 3);
    if (tick_times.size() >= 3) begin
      check("t3_period_cur", tick_times[0] - s, 4);
      check("t3_period_new", tick_times[1] - tick_times[0], 8);
      check("t3_period_next", tick_times[2] - tick_times[1], 8);
    end
    STOP = 1; step_clk(); STOP = 0;

    // STOP on the wrap edge, then START+STOP together in idle
    do_reset();
    cfg_div(3);
    pulse_start();
    tick_times.delete();
    for (int i = 0; i < 3; i++) step_clk();
    STOP = 1;
    step_clk();
    STOP = 0;
    check("t4_stop_tick", int'(TICK), 0);
    check("t4_stop_running", int'(RUNNING), 0);
    check("t4_stop_counter", int'(dut.counter_q), 0);
    for (int i = 0; i < 8; i++) step_clk();
    check("t4_idle_no_ticks", tick_times.size(), 0);
    START = 1; STOP = 1;
    step_clk();
    clear_inputs();
    check("t4_start_stop_idle", int'(RUNNING), 0);
    step_clk();
    check("t4_still_idle", int'(RUNNING), 0);

    // divisor 0: tick every cycle, count wraps, reset mid-run
    do_reset();
    cfg_div(0);
    pulse_start();
    tick_times.delete();
    for (int i = 0; i < 256; i++) step_clk();
    check("t5_ticks", tick_times.size(), 256);
    check("t5_count_wrap", int'(TICK_COUNT), 0);
    for (int i = 0; i < 3; i++) step_clk();
    check("t5_count_after", int'(TICK_COUNT), 3);
    RESET = 1;
    step_clk();
    RESET = 0;
    check("t5_rst_tick", int'(TICK), 0);
    check("t5_rst_running", int'(RUNNING), 0);
    check("t5_rst_ready", int'(CFG_READY), 1);
    check("t5_rst_count", int'(TICK_COUNT), 0);

`ifdef READ_CLK_SQUARE_OUT_EN
    // square output with divisor 3: 8-cycle period, half high
    do_reset();
    cfg_div(3);
    pulse_start();
    for (int i = 0; i < 4; i++) step_clk();
    ones = 0;
    for (int i = 0; i < 16; i++) begin
      step_clk();
      ones += int'(OUT);
    end
    check("t6_out_duty", ones, 8);
    STOP = 1; step_clk(); STOP = 0;
`endif

    // random stimulus against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      RESET     = ($urandom_range(0, 499) == 0);
      START     = ($urandom_range(0, 19) == 0);
      STOP      = ($urandom_range(0, 39) == 0);
      STEP      = ($urandom_range(0, 19) == 0);
      CFG_VALID = ($urandom_range(0, 5) == 0);
      CFG_DIV   = CW'($urandom_range(0, 12));
      step_clk();
    end
    clear_inputs();
    RESET = 0;
    step_clk();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
